// File: rtl/risc_pipe_pkg.sv
// Shared constants for RISC pipeline stage registers: NOP word, instruction
// field positions and occupancy width.
package risc_pipe_pkg;

   localparam logic [15:0] NOP_INSTR_DEF = 16'hF000;

   localparam int unsigned REG_ADDR_W = 3;
   localparam int unsigned IMM6_W     = 6;
   localparam int unsigned IMM9_W     = 9;

   localparam int unsigned RA_MSB   = 11;
   localparam int unsigned RA_LSB   = 9;
   localparam int unsigned RB_MSB   = 8;
   localparam int unsigned RB_LSB   = 6;
   localparam int unsigned RC_MSB   = 5;
   localparam int unsigned RC_LSB   = 3;
   localparam int unsigned IMM6_MSB = 5;
   localparam int unsigned IMM9_MSB = 8;

   localparam int unsigned OCC_W = 2;

endpackage

// File: rtl/instr_field_dec.sv
// Combinational extraction of register addresses and immediates from an
// instruction word; bit positions are fixed regardless of INSTR_W.
module instr_field_dec
   import risc_pipe_pkg::*;
#(
   parameter int unsigned INSTR_W = 16
) (
   input  logic [INSTR_W-1:0]    instr_i,
   output logic [REG_ADDR_W-1:0] ra_add_o,
   output logic [REG_ADDR_W-1:0] rb_add_o,
   output logic [REG_ADDR_W-1:0] rc_add_o,
   output logic [IMM6_W-1:0]     imm_6_o,
   output logic [IMM9_W-1:0]     imm_9_o
);

   // Opcode bits above the register fields are not decoded here
   logic unused_hi_bits;
   assign unused_hi_bits = ^instr_i[INSTR_W-1:RA_MSB+1];

   assign ra_add_o = instr_i[RA_MSB:RA_LSB];
   assign rb_add_o = instr_i[RB_MSB:RB_LSB];
   assign rc_add_o = instr_i[RC_MSB:RC_LSB];
   assign imm_6_o  = instr_i[IMM6_MSB:0];
   assign imm_9_o  = instr_i[IMM9_MSB:0];

endmodule

// File: rtl/pipe_stage_skid.sv
// Fetch->decode stage register with one skid entry so in_ready can be a flop
// with no combinational path from out_ready.
module pipe_stage_skid
   import risc_pipe_pkg::*;
#(
   parameter int unsigned        INSTR_W   = 16,
   parameter int unsigned        PC_W      = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PC_W-1:0]       in_pc,
   input  logic [PC_W-1:0]       in_pc2,
   input  logic [INSTR_W-1:0]    in_instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PC_W-1:0]       out_pc,
   output logic [PC_W-1:0]       out_pc2,
   output logic [INSTR_W-1:0]    out_instr,
   input  logic                  flush,
   output logic [REG_ADDR_W-1:0] ra_add,
   output logic [REG_ADDR_W-1:0] rb_add,
   output logic [REG_ADDR_W-1:0] rc_add,
   output logic [IMM6_W-1:0]     imm_6,
   output logic [IMM9_W-1:0]     imm_9,
   output logic [OCC_W-1:0]      occupancy
);

   logic               main_valid_q, main_valid_d;
   logic [PC_W-1:0]    main_pc_q,    main_pc_d;
   logic [PC_W-1:0]    main_pc2_q,   main_pc2_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;

   logic               skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
   logic [PC_W-1:0]    skid_pc2_q,   skid_pc2_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

   logic               in_ready_q,   in_ready_d;
   logic [OCC_W-1:0]   occ_q,        occ_d;

   logic               accept;
   logic               drain;

   // Next-state: flush empties both entries; skid always refills main first
   always_comb begin
      main_valid_d = main_valid_q;
      main_pc_d    = main_pc_q;
      main_pc2_d   = main_pc2_q;
      main_instr_d = main_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_pc2_d   = skid_pc2_q;
      skid_instr_d = skid_instr_q;

      accept = in_valid && in_ready_q;
      drain  = main_valid_q && out_ready;

      if (flush) begin
         main_valid_d = 1'b0;
         main_pc_d    = '0;
         main_pc2_d   = '0;
         main_instr_d = NOP_INSTR;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || drain) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_pc_d    = skid_pc_q;
            main_pc2_d   = skid_pc2_q;
            main_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_pc_d    = in_pc;
            main_pc2_d   = in_pc2;
            main_instr_d = in_instr;
         end else begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_pc2_d   = '0;
            main_instr_d = NOP_INSTR;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_pc_d    = in_pc;
         skid_pc2_d   = in_pc2;
         skid_instr_d = in_instr;
      end

      in_ready_d = !skid_valid_d;
      occ_d      = OCC_W'(main_valid_d) + OCC_W'(skid_valid_d);
   end

   // Main entry; payload is forced to 0/NOP whenever empty
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_pc_q    <= '0;
         main_pc2_q   <= '0;
         main_instr_q <= NOP_INSTR;
      end else begin
         main_valid_q <= main_valid_d;
         main_pc_q    <= main_pc_d;
         main_pc2_q   <= main_pc2_d;
         main_instr_q <= main_instr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_pc2_q   <= '0;
         skid_instr_q <= NOP_INSTR;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_pc2_q   <= skid_pc2_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q <= 1'b1;
         occ_q      <= '0;
      end else begin
         in_ready_q <= in_ready_d;
         occ_q      <= occ_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_pc    = main_pc_q;
   assign out_pc2   = main_pc2_q;
   assign out_instr = main_instr_q;
   assign occupancy = occ_q;

   instr_field_dec #(
      .INSTR_W (INSTR_W)
   ) u_dec (
      .instr_i  (main_instr_q),
      .ra_add_o (ra_add),
      .rb_add_o (rb_add),
      .rc_add_o (rc_add),
      .imm_6_o  (imm_6),
      .imm_9_o  (imm_9)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, all
// outputs compared each cycle against a queue model of held words.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_pc, in_pc2, in_instr, out_pc, out_pc2, out_instr;
   logic [2:0]  ra_add, rb_add, rc_add;
   logic [5:0]  imm_6;
   logic [8:0]  imm_9;
   logic [1:0]  occupancy;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] pc2;
      logic [15:0] instr;
   } word_t;

   word_t mq[$];
   int    n_vec = 0;
   int    n_err = 0;

   pipe_stage_skid dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_pc2    (in_pc2),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_pc2   (out_pc2),
      .out_instr (out_instr),
      .flush     (flush),
      .ra_add    (ra_add),
      .rb_add    (rb_add),
      .rc_add    (rc_add),
      .imm_6     (imm_6),
      .imm_9     (imm_9),
      .occupancy (occupancy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model at the edge, settle #1 after
   task automatic drive_cycle(input logic v, input logic r, input logic f, input logic rs,
                              input logic [15:0] ins, input logic [15:0] pc);
      word_t w;
      bit    acc, drn;
      in_valid  = v;
      out_ready = r;
      flush     = f;
      rst       = rs;
      in_instr  = ins;
      in_pc     = pc;
      in_pc2    = pc + 16'd2;
      w.pc      = pc;
      w.pc2     = pc + 16'd2;
      w.instr   = ins;
      @(posedge clk);
      if (rs || f) begin
         mq.delete();
      end else begin
         acc = v && (mq.size() < 2);
         drn = r && (mq.size() > 0);
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(w);
      end
      #1;
   endtask

   task automatic check_all(input string tag);
      word_t e;
      if (mq.size() > 0) e = mq[0];
      else begin
         e.pc    = 16'h0;
         e.pc2   = 16'h0;
         e.instr = 16'hF000;
      end
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
      chk({tag, ".out_instr"}, 32'(out_instr), 32'(e.instr));
      chk({tag, ".out_pc"},    32'(out_pc),    32'(e.pc));
      chk({tag, ".out_pc2"},   32'(out_pc2),   32'(e.pc2));
      chk({tag, ".ra_add"},    32'(ra_add),    32'((e.instr >> 9) % 16'd8));
      chk({tag, ".rb_add"},    32'(rb_add),    32'((e.instr >> 6) % 16'd8));
      chk({tag, ".rc_add"},    32'(rc_add),    32'((e.instr >> 3) % 16'd8));
      chk({tag, ".imm_6"},     32'(imm_6),     32'(e.instr % 16'd64));
      chk({tag, ".imm_9"},     32'(imm_9),     32'(e.instr % 16'd512));
      chk({tag, ".occ_inv"},   32'(occupancy == 2'd2 && !out_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] stream [3];
      stream[0] = 16'h1234;
      stream[1] = 16'h5678;
      stream[2] = 16'h9ABC;

      // Reset state
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      check_all("reset");
      chk("reset.nop", 32'(out_instr), 32'h0000F000);
      chk("reset.rdy", 32'(in_ready), 32'd1);

      // Streaming at full rate
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, stream[i], 16'(16'h100 + 2 * i));
         check_all("stream");
         chk("stream.instr", 32'(out_instr), 32'(stream[i]));
         chk("stream.occ", 32'(occupancy), 32'd1);
      end
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      check_all("stream_drain");

      // Backpressure: third word is refused
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h200);
      check_all("bp1");
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h202);
      check_all("bp2");
      chk("bp2.rdy", 32'(in_ready), 32'd0);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h204);
      check_all("bp3");
      chk("bp3.occ", 32'(occupancy), 32'd2);
      chk("bp3.hold", 32'(out_instr), 32'h00001111);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      check_all("bp_drain1");
      chk("bp_drain1.instr", 32'(out_instr), 32'h00002222);
      chk("bp_drain1.rdy", 32'(in_ready), 32'd1);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      check_all("bp_drain2");

      // Flush with a word offered in the same cycle
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hBBBB, 16'h300);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hCCCC, 16'h302);
      check_all("pre_flush");
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h304);
      check_all("flush");
      chk("flush.instr", 32'(out_instr), 32'h0000F000);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      check_all("post_flush");

      // Reset mid-operation, then single-cycle latency
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hDDDD, 16'h400);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hEEEE, 16'h402);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h404);
      check_all("mid_reset");
      chk("mid_reset.occ", 32'(occupancy), 32'd0);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h5A5A, 16'h406);
      check_all("post_reset");
      chk("post_reset.instr", 32'(out_instr), 32'h00005A5A);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

      // Field decode
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'b0011_1010_1100_0101, 16'h500);
      check_all("decode");
      chk("decode.ra", 32'(ra_add), 32'b101);
      chk("decode.rb", 32'(rb_add), 32'b011);
      chk("decode.rc", 32'(rc_add), 32'b000);
      chk("decode.imm6", 32'(imm_6), 32'b000101);
      chk("decode.imm9", 32'(imm_9), 32'b011000101);

      // Random valid/ready/flush/reset traffic
      for (int i = 0; i < 500; i++) begin
         drive_cycle($urandom_range(9) < 7, $urandom_range(9) < 6,
                     $urandom_range(19) == 0, $urandom_range(99) == 0,
                     16'($urandom), 16'($urandom));
         check_all("rand");
      end

      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      check_all("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter: INSTR_W, default 16, instruction word width.
REQ-002 SHALL have parameter: PC_W, default 16, PC and PC+2 width.
REQ-003 SHALL have parameter: NOP_INSTR, default 16'hF000, word driven on out_instr when the stage is empty or flushed.
REQ-004 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: in_valid  in  1; in_ready  out  1; in_pc  in  PC_W; in_pc2  in  PC_W; in_instr  in  INSTR_W. These form the upstream (fetch) handshake.
REQ-007 SHALL have ports: out_valid  out  1; out_ready  in  1; out_pc  out  PC_W; out_pc2  out  PC_W; out_instr  out  INSTR_W. These form the downstream (decode) handshake.
REQ-008 SHALL have port: flush  in  1  discard all held and incoming words.
REQ-009 SHALL have ports: ra_add, rb_add, rc_add  out  3 each; imm_6  out  6; imm_9  out  9. These are decoded fields of out_instr.
REQ-010 SHALL have port: occupancy  out  2  number of held words (0..2).

Function
REQ-011 SHALL transfer upstream when in_valid && in_ready, and downstream when out_valid && out_ready, both sampled at the rising edge.
REQ-012 SHALL hold two entries: a main output register and one skid register; words leave in acceptance order.
REQ-013 SHALL drive in_ready from a flop, equal to !skid_full; no combinational path from out_ready to in_ready.
REQ-014 SHALL present a word accepted at edge N on the out_* ports after edge N (latency 1) when main is empty or drains at edge N.
REQ-015 SHALL place the accepted word in skid when main is full and is not drained at the same edge; skid_full rises and in_ready is 0 from the next cycle.
REQ-016 SHALL move skid to main when main drains while skid is full; at the same edge skid empties and in_ready returns to 1.
REQ-017 SHALL, on simultaneous accept and drain with main full and skid empty, load the new word into main; occupancy stays at 1.
REQ-018 SHALL hold out_* values constant while out_valid && !out_ready.
REQ-019 SHALL drive out_valid = main_full, and drive out_pc/out_pc2 = 0 and out_instr = NOP_INSTR when main is empty.
REQ-020 SHALL decode fields combinationally from out_instr: ra_add = [11:9], rb_add = [8:6], rc_add = [5:3], imm_6 = [5:0], imm_9 = [8:0]; for INSTR_W > 16, bit positions are unchanged.
REQ-021 SHALL, when flush = 1, empty both entries at that edge, discard any word offered in the same cycle, and set in_ready = 1 next cycle; flush has priority over accept and drain.
REQ-022 SHALL allow a downstream transfer completing in a flush cycle to be counted by the consumer; state after the edge is empty.
REQ-023 SHALL drive occupancy = main_full + skid_full, and never indicate skid full while main is empty.

Reset
REQ-024 SHALL, when rst = 1 at an edge, clear main and skid, set out_valid = 0, in_ready = 1, occupancy = 0, out_pc = out_pc2 = 0, and out_instr = NOP_INSTR.
REQ-025 SHALL give rst priority over flush and all handshakes; a word accepted in a reset cycle is lost.
REQ-026 SHALL keep in_ready = 0 only while skid is full; after reset, it is 1 in the first cycle.

Structure
REQ-027 SHALL place NOP_INSTR default, field bit positions (RA_MSB etc.) and the occupancy width in shared package risc_pipe_pkg.
REQ-028 SHALL instantiate one sub-module instr_field_dec (combinational field extraction), reusable by later stage registers.
REQ-029 SHALL use one always block per entry register and no latches, with all outputs from flops or from instr_field_dec.

Verification
REQ-030 SHALL verify streaming: in_valid = 1 with instr 16'h1234, 16'h5678, 16'h9ABC, out_ready = 1 -> out_instr shows the same sequence one cycle later, occupancy = 1 throughout, and in_ready is never 0.
REQ-031 SHALL verify backpressure: out_ready = 0 while 3 words are offered -> 2 accepted, in_ready = 0 from cycle 3, occupancy = 2; out_ready = 1 -> words drain in order and in_ready = 1 one cycle after the first drain.
REQ-032 SHALL verify flush: occupancy = 2, then flush with in_valid = 1 (instr 16'hAAAA) -> next cycle out_valid = 0, out_instr = 16'hF000, occupancy = 0, and 16'hAAAA is never output.
REQ-033 SHALL verify reset mid-operation: rst pulsed with occupancy = 2 and out_ready = 0 -> all outputs at reset values next cycle, and the next accepted word appears after 1 cycle.
REQ-034 SHALL verify decode: instr 16'b0011_1010_1100_0101 -> ra_add = 3'b101, rb_add = 3'b011, rc_add = 3'b000, imm_6 = 6'b000101, imm_9 = 9'b011000101.
REQ-035 SHALL verify, with a random valid/ready/flush checker, no loss or duplication outside flush and the occupancy invariant.
